// File: rtl/ram_arbiter.sv
// Round-robin arbiter that serialises two masters onto one single-port RAM with a shared tristate bus.
// Each access takes three cycles: grant in IDLE, RAM access in ACC, and an ack pulse in RESP.
module ram_arbiter #(
  parameter int d_addr_bits = 6,
  parameter int data_bits   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [d_addr_bits-1:0] a_addr,
  input  logic [data_bits-1:0]   a_wdata,
  output logic                   a_ack,
  output logic [data_bits-1:0]   a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [d_addr_bits-1:0] b_addr,
  input  logic [data_bits-1:0]   b_wdata,
  output logic                   b_ack,
  output logic [data_bits-1:0]   b_rdata,
  output logic                   d_mem_we,
  output logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [data_bits-1:0]   d_mem_data
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t                 state;
  logic                   last_grant;  // 1 = B was granted last
  logic                   owner;       // 1 = B owns the access in flight
  logic                   we_q;
  logic [d_addr_bits-1:0] addr_q;
  logic [data_bits-1:0]   wdata_q;
  logic                   grant_b;

  // B wins when it is the only requester, or when both request and A was granted last.
  assign grant_b = b_req & ~(a_req & last_grant);

  // The reset term is combinational so a write is blocked within the same cycle reset rises.
  assign d_mem_we   = (state == ACC) & we_q & ~reset;
  assign d_mem_addr = addr_q;
  assign d_mem_data = d_mem_we ? wdata_q : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            owner      <= grant_b;
            last_grant <= grant_b;
            we_q       <= grant_b ? b_we    : a_we;
            addr_q     <= grant_b ? b_addr  : a_addr;
            wdata_q    <= grant_b ? b_wdata : a_wdata;
            state      <= ACC;
          end
        end
        ACC: begin
          if (!we_q) begin
            if (owner) b_rdata <= d_mem_data;
            else       a_rdata <= d_mem_data;
          end
          a_ack <= ~owner;
          b_ack <= owner;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM on the shared bus, a shadow-memory reference model,
// directed scenarios followed by randomized single and contending transactions.
module tb_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          preload;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          d_mem_we;
  logic [AW-1:0] d_mem_addr;
  wire  [DW-1:0] d_mem_data;

  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];
  logic          last_was_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int a_acks = 0;
  int b_acks = 0;
  int we_cycles = 0;
  int ev_port[$];
  int ev_cyc[$];

  always #5 clk = ~clk;

  ram_arbiter #(.d_addr_bits(AW), .data_bits(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr), .d_mem_data(d_mem_data)
  );

  // Behavioural RAM: drives the bus whenever it is not being written.
  assign d_mem_data = d_mem_we ? 'z : mem[d_mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= DW'(i);
    end else if (d_mem_we) begin
      mem[d_mem_addr] <= d_mem_data;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (d_mem_we) we_cycles <= we_cycles + 1;
    if (a_ack) a_acks <= a_acks + 1;
    if (b_ack) b_acks <= b_acks + 1;
    if (a_ack || b_ack) begin
      chk("ack_exclusive", DW'(a_ack & b_ack), '0);
      ev_port.push_back(b_ack ? 1 : 0);
      ev_cyc.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: apply one operation to the shadow memory, returning expected rdata.
  task automatic model_op(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                          inout logic [DW-1:0] exp_rd);
    if (we) ref_mem[ad] = wd;
    else    exp_rd = ref_mem[ad];
  endtask

  task automatic do_txn(input logic port, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    int a0, b0, w0, n;
    logic got;
    logic [DW-1:0] exp_rd;
    a0 = a_acks; b0 = b_acks; w0 = we_cycles; n = 0; got = 1'b0;
    exp_rd = port ? b_rdata : a_rdata;
    model_op(we, ad, wd, exp_rd);
    if (port) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
    while (!got && n < 10) begin
      tick;
      n++;
      // Fields change after the grant edge; the latched copy must be used.
      if (n == 1) begin
        if (port) begin b_we = ~we; b_addr = ~ad; b_wdata = ~wd; end
        else      begin a_we = ~we; a_addr = ~ad; a_wdata = ~wd; end
      end
      got = port ? b_ack : a_ack;
    end
    a_req = 0; b_req = 0;
    chk("txn_ack_seen", DW'(got), 1);
    chk("txn_latency", DW'(n), 2);
    chk("txn_rdata", port ? b_rdata : a_rdata, exp_rd);
    tick;
    chk("txn_ack_count_a", DW'(a_acks - a0), DW'(port ? 0 : 1));
    chk("txn_ack_count_b", DW'(b_acks - b0), DW'(port ? 1 : 0));
    chk("txn_we_cycles", DW'(we_cycles - w0), DW'(we ? 1 : 0));
    last_was_b = port;
  endtask

  task automatic do_pair(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic win_b;
    logic [DW-1:0] ea, eb;
    int t, ta, tb;
    win_b = ~last_was_b;
    ea = a_rdata; eb = b_rdata;
    if (win_b) begin model_op(wb, ab, db, eb); model_op(wa, aa, da, ea); end
    else       begin model_op(wa, aa, da, ea); model_op(wb, ab, db, eb); end
    a_req = 1; a_we = wa; a_addr = aa; a_wdata = da;
    b_req = 1; b_we = wb; b_addr = ab; b_wdata = db;
    t = 0; ta = -1; tb = -1;
    while ((ta < 0 || tb < 0) && t < 16) begin
      tick;
      t++;
      if (a_ack && ta < 0) begin ta = t; a_req = 0; end
      if (b_ack && tb < 0) begin tb = t; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    chk("pair_both_acked", DW'(ta > 0 && tb > 0), 1);
    chk("pair_winner_first", DW'(win_b ? (tb < ta) : (ta < tb)), 1);
    chk("pair_ack_spacing", DW'(win_b ? ta - tb : tb - ta), 3);
    chk("pair_a_rdata", a_rdata, ea);
    chk("pair_b_rdata", b_rdata, eb);
    tick;
    last_was_b = ~win_b;
  endtask

  initial begin
    int a0, w0, n, seen;
    logic [DW-1:0] rd;
    reset = 1; preload = 1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = DW'(i);
    last_was_b = 1'b1;
    repeat (3) tick;
    preload = 0;
    chk("rst_a_ack", DW'(a_ack), 0);
    chk("rst_b_ack", DW'(b_ack), 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_we", DW'(d_mem_we), 0);
    chk("rst_addr", DW'(d_mem_addr), 0);

    // Both ports request continuously from reset: grants alternate starting with A.
    a_req = 1; a_we = 0; a_addr = 6'd1;
    b_req = 1; b_we = 0; b_addr = 6'd2;
    tick;
    reset = 0;
    n = 0;
    while (ev_port.size() < 4 && n < 30) begin tick; n++; end
    a_req = 0; b_req = 0;
    chk("tie_four_acks", DW'(ev_port.size() >= 4), 1);
    if (ev_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("tie_order", DW'(ev_port[i]), DW'(i % 2));
      for (int i = 0; i < 3; i++) chk("tie_spacing", DW'(ev_cyc[i+1] - ev_cyc[i]), 3);
    end
    chk("tie_a_rdata", a_rdata, 1);
    chk("tie_b_rdata", b_rdata, 2);
    chk("tie_no_writes", DW'(we_cycles), 0);
    tick; tick;
    last_was_b = 1'b1;

    do_txn(1'b0, 1'b0, 6'd5, '0);
    do_txn(1'b1, 1'b1, 6'd10, 64'hDEADBEEF_CAFEF00D);
    do_txn(1'b0, 1'b0, 6'd10, '0);

    // Reset lands in the ACC cycle of a write: no RAM write, no ack.
    a0 = a_acks; w0 = we_cycles;
    a_req = 1; a_we = 1; a_addr = 6'd3; a_wdata = 64'h55;
    tick;
    chk("abort_addr_in_acc", DW'(d_mem_addr), 3);
    reset = 1;
    #1;
    chk("abort_we_suppressed", DW'(d_mem_we), 0);
    tick;
    a_req = 0; reset = 0;
    chk("abort_a_rdata_clr", a_rdata, 0);
    chk("abort_b_rdata_clr", b_rdata, 0);
    chk("abort_addr_clr", DW'(d_mem_addr), 0);
    repeat (4) tick;
    chk("abort_no_ack", DW'(a_acks - a0), 0);
    chk("abort_no_write", DW'(we_cycles - w0), 0);
    last_was_b = 1'b1;
    do_txn(1'b0, 1'b0, 6'd3, '0);

    // Request dropped right after the grant still completes exactly once.
    a0 = a_acks;
    a_req = 1; a_we = 0; a_addr = 6'd7;
    tick;
    a_req = 0;
    n = 0;
    while (!a_ack && n < 8) begin tick; n++; end
    chk("drop_ack_seen", DW'(a_ack), 1);
    chk("drop_rdata", a_rdata, ref_mem[7]);
    repeat (6) tick;
    chk("drop_single_ack", DW'(a_acks - a0), 1);
    last_was_b = 1'b0;

    // Request held through the ack cycle is re-arbitrated as a second transaction.
    a0 = a_acks;
    a_req = 1; a_we = 0; a_addr = 6'd9;
    n = 0; seen = 0;
    while (seen < 2 && n < 15) begin
      tick; n++;
      if (a_ack) seen++;
    end
    a_req = 0;
    chk("hold_two_acks", DW'(seen), 2);
    chk("hold_cycles", DW'(n), 5);
    chk("hold_rdata", a_rdata, ref_mem[9]);
    repeat (4) tick;
    chk("hold_ack_total", DW'(a_acks - a0), 2);
    last_was_b = 1'b0;

    for (int i = 0; i < 30; i++) begin
      rd = {$urandom, $urandom};
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), rd);
    end
    for (int i = 0; i < 12; i++) begin
      rd = {$urandom, $urandom};
      do_pair(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), rd,
              1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), ~rd);
    end

    repeat (2) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
